// File: rtl/controlador_interrupcoes_pkg.sv
// controlador_interrupcoes_pkg: FSM state encoding, channel indices and cause-code helper for the interrupt controller
package controlador_interrupcoes_pkg;
  typedef enum logic [1:0] {OCIOSO, DESVIO, ATENDIMENTO} estado_t;
  localparam int CH_HALT = 0;
  localparam int CH_TIMER = 1;
  function automatic int unsigned codigo_causa(input int unsigned idx);
    return idx + 1;
  endfunction
endpackage

// File: rtl/controlador_interrupcoes_temporizador_quantum.sv
// temporizador_quantum: reloading quantum counter (set_clock/int_time load, freeze holds, expire pulses on the 1->0 step)
module temporizador_quantum #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   set_clock,
  input  logic [TIMER_WIDTH-1:0] int_time,
  input  logic                   freeze,
  output logic                   expire
);
  logic [TIMER_WIDTH-1:0] quantum, counter;
  assign expire = !set_clock && !freeze && quantum != '0 && counter == TIMER_WIDTH'(1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      quantum <= '0;
      counter <= '0;
    end else if (set_clock) begin
      quantum <= int_time;
      counter <= int_time;
    end else if (!freeze && quantum != '0)
      counter <= expire ? quantum : counter - TIMER_WIDTH'(1);
endmodule

// File: rtl/controlador_interrupcoes.sv
// controlador_interrupcoes: edge-latched pending requests, fixed-priority capture to VECTOR_ADDR with saved return PC, cause, mask, quantum timer and in-service lock
module controlador_interrupcoes
  import controlador_interrupcoes_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 13,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_IRQ     = 4,
  parameter int                  TIMER_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   halt,
  input  logic [NUM_IRQ-3:0]     irq_ext,
  input  logic                   set_clock,
  input  logic [TIMER_WIDTH-1:0] int_time,
  input  logic                   mask_write,
  input  logic [NUM_IRQ-1:0]     mask_data,
  input  logic [ADDR_WIDTH-1:0]  pc_next,
  input  logic                   get_interruption,
  input  logic                   os_return,
  output logic                   int_take,
  output logic [ADDR_WIDTH-1:0]  int_vector,
  output logic [ADDR_WIDTH-1:0]  pc_interrup,
  output logic [DATA_WIDTH-1:0]  qual_interrupcao,
  output logic                   in_service,
  output logic [NUM_IRQ-1:0]     pending
);
  localparam int IW = $clog2(NUM_IRQ);
  estado_t state, next_state;
  logic [NUM_IRQ-1:0] mask, events, ativo, clr;
  logic [NUM_IRQ-3:0] ext_prev;
  logic [IW-1:0] idx;
  logic halt_prev, expire, capture;
  function automatic logic [IW-1:0] prioridade(input logic [NUM_IRQ-1:0] v);
    prioridade = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) prioridade = IW'(i);
  endfunction
  temporizador_quantum #(.TIMER_WIDTH(TIMER_WIDTH)) u_temporizador (
    .clock(clock),
    .reset_n(reset_n),
    .set_clock(set_clock),
    .int_time(int_time),
    .freeze(state != OCIOSO),
    .expire(expire)
  );
  always_comb begin
    events = {irq_ext & ~ext_prev, 2'b00};
    events[CH_HALT] = halt & ~halt_prev;
    events[CH_TIMER] = expire;
  end
  assign ativo = pending & mask;
  assign idx = prioridade(ativo);
  assign capture = state == OCIOSO && |ativo;
  assign clr = capture ? NUM_IRQ'(1) << idx : '0;
  assign int_take = state == DESVIO;
  assign in_service = state == ATENDIMENTO;
  assign int_vector = VECTOR_ADDR;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= OCIOSO;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      OCIOSO:      if (capture) next_state = DESVIO;
      DESVIO:      next_state = ATENDIMENTO;
      ATENDIMENTO: if (os_return) next_state = OCIOSO;
      default:     next_state = OCIOSO;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      halt_prev <= 1'b0;
      ext_prev <= '0;
      pending <= '0;
      mask <= '1;
      qual_interrupcao <= '0;
      pc_interrup <= '0;
    end else begin
      halt_prev <= halt;
      ext_prev <= irq_ext;
      pending <= (pending & ~clr) | events;
      if (mask_write) mask <= mask_data;
      if (capture) pc_interrup <= pc_next;
      if (capture) qual_interrupcao <= DATA_WIDTH'(codigo_causa(32'(idx)));
      else if (get_interruption) qual_interrupcao <= '0;
    end
endmodule

// File: tb/tb_controlador_interrupcoes.sv
// tb_controlador_interrupcoes: directed literal checks plus randomized run against a cycle-level behavioural model
module tb_controlador_interrupcoes;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int N = 4;
  localparam int TW = 16;
  logic clock = 0, reset_n = 1, halt = 0, set_clock = 0, mask_write = 0, get_interruption = 0, os_return = 0;
  logic [N-3:0] irq_ext = '0;
  logic [TW-1:0] int_time = '0;
  logic [N-1:0] mask_data = '0;
  logic [AW-1:0] pc_next = '0;
  logic int_take, in_service;
  logic [AW-1:0] int_vector, pc_interrup;
  logic [DW-1:0] qual_interrupcao;
  logic [N-1:0] pending;
  int checks = 0, failures = 0;
  int m_phase = 0, m_cause = 0;
  bit [N-1:0] m_pend = '0, m_mask = '1;
  logic [TW-1:0] m_q = '0, m_c = '0;
  logic [AW-1:0] m_pc = '0;
  bit m_halt_p = 0;
  bit [N-3:0] m_ext_p = '0;
  always #5 clock = ~clock;
  controlador_interrupcoes dut (
    .clock(clock),
    .reset_n(reset_n),
    .halt(halt),
    .irq_ext(irq_ext),
    .set_clock(set_clock),
    .int_time(int_time),
    .mask_write(mask_write),
    .mask_data(mask_data),
    .pc_next(pc_next),
    .get_interruption(get_interruption),
    .os_return(os_return),
    .int_take(int_take),
    .int_vector(int_vector),
    .pc_interrup(pc_interrup),
    .qual_interrupcao(qual_interrupcao),
    .in_service(in_service),
    .pending(pending)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_phase = 0;
      m_pend = '0;
      m_mask = '1;
      m_q = '0;
      m_c = '0;
      m_cause = 0;
      m_pc = '0;
      m_halt_p = 0;
      m_ext_p = '0;
    end else begin
      bit [N-1:0] ev;
      int win;
      ev = '0;
      win = -1;
      ev[0] = halt && !m_halt_p;
      for (int i = 0; i < N - 2; i++) ev[i+2] = irq_ext[i] && !m_ext_p[i];
      if (set_clock) begin
        m_q = int_time;
        m_c = int_time;
      end else if (m_phase == 0 && m_q != 0) begin
        if (m_c == 1) begin
          ev[1] = 1;
          m_c = m_q;
        end else m_c = m_c - 1;
      end
      if (m_phase == 0)
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
      if (win >= 0) begin
        m_cause = win + 1;
        m_pc = pc_next;
        m_pend[win] = 0;
      end else if (get_interruption) m_cause = 0;
      m_pend = m_pend | ev;
      if (mask_write) m_mask = mask_data;
      m_halt_p = halt;
      m_ext_p = irq_ext;
      if (win >= 0) m_phase = 1;
      else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && os_return) m_phase = 0;
    end
  always @(negedge clock) begin
    check("m_int_take", 64'(int_take), 64'(m_phase == 1));
    check("m_in_service", 64'(in_service), 64'(m_phase == 2));
    check("m_pending", 64'(pending), 64'(m_pend));
    check("m_cause", 64'(qual_interrupcao), 64'(m_cause));
    check("m_pc_interrup", 64'(pc_interrup), 64'(m_pc));
    check("m_int_vector", 64'(int_vector), 64'(0));
  end
  initial begin
    #1 reset_n = 0;
    #20;
    check("rst_int_take", 64'(int_take), 64'(0));
    check("rst_in_service", 64'(in_service), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_cause", 64'(qual_interrupcao), 64'(0));
    check("rst_pc", 64'(pc_interrup), 64'(0));
    @(posedge clock);
    #1 reset_n = 1;
    tick(3);
    halt = 1;
    tick(1);
    check("halt_pending", 64'(pending), 64'h1);
    check("halt_no_take_yet", 64'(int_take), 64'(0));
    halt = 0;
    pc_next = 13'h0123;
    tick(1);
    check("halt_take", 64'(int_take), 64'(1));
    check("halt_cause", 64'(qual_interrupcao), 64'(1));
    check("halt_pc", 64'(pc_interrup), 64'h123);
    check("halt_pending_clr", 64'(pending), 64'(0));
    tick(1);
    check("halt_take_end", 64'(int_take), 64'(0));
    check("halt_in_service", 64'(in_service), 64'(1));
    os_return = 1;
    tick(1);
    os_return = 0;
    check("halt_return", 64'(in_service), 64'(0));
    set_clock = 1;
    int_time = 4;
    tick(1);
    set_clock = 0;
    tick(3);
    check("timer_not_yet", 64'(pending), 64'(0));
    tick(1);
    check("timer_pending", 64'(pending), 64'h2);
    tick(1);
    check("timer_take", 64'(int_take), 64'(1));
    check("timer_cause", 64'(qual_interrupcao), 64'(2));
    set_clock = 1;
    int_time = 0;
    tick(1);
    set_clock = 0;
    os_return = 1;
    tick(1);
    os_return = 0;
    tick(8);
    check("timer_off", 64'(pending), 64'(0));
    halt = 1;
    irq_ext = 2'b01;
    tick(1);
    check("both_pending", 64'(pending), 64'h5);
    halt = 0;
    irq_ext = 2'b00;
    tick(1);
    check("both_first_cause", 64'(qual_interrupcao), 64'(1));
    check("both_ext_left", 64'(pending), 64'h4);
    tick(1);
    os_return = 1;
    tick(1);
    os_return = 0;
    check("both_idle", 64'(in_service), 64'(0));
    tick(1);
    check("both_second_take", 64'(int_take), 64'(1));
    check("both_second_cause", 64'(qual_interrupcao), 64'(3));
    tick(1);
    os_return = 1;
    tick(1);
    os_return = 0;
    mask_write = 1;
    mask_data = 4'b1101;
    set_clock = 1;
    int_time = 2;
    tick(1);
    mask_write = 0;
    set_clock = 0;
    tick(2);
    check("mask_pending_held", 64'(pending), 64'h2);
    set_clock = 1;
    int_time = 0;
    tick(1);
    set_clock = 0;
    check("mask_no_take", 64'(int_take), 64'(0));
    mask_write = 1;
    mask_data = 4'b1111;
    tick(1);
    mask_write = 0;
    check("mask_write_edge_no_take", 64'(int_take), 64'(0));
    tick(1);
    check("unmask_take", 64'(int_take), 64'(1));
    check("unmask_cause", 64'(qual_interrupcao), 64'(2));
    tick(1);
    halt = 1;
    get_interruption = 1;
    tick(1);
    halt = 0;
    get_interruption = 0;
    check("get_cause_zero", 64'(qual_interrupcao), 64'(0));
    check("get_pending_set", 64'(pending), 64'h1);
    check("get_still_service", 64'(in_service), 64'(1));
    os_return = 1;
    tick(1);
    os_return = 0;
    tick(1);
    check("get_retake", 64'(int_take), 64'(1));
    check("get_recause", 64'(qual_interrupcao), 64'(1));
    #2 reset_n = 0;
    #1;
    check("async_take", 64'(int_take), 64'(0));
    check("async_cause", 64'(qual_interrupcao), 64'(0));
    check("async_pc", 64'(pc_interrup), 64'(0));
    @(posedge clock);
    #1 reset_n = 1;
    irq_ext = 2'b10;
    tick(1);
    irq_ext = 2'b00;
    check("post_rst_pending", 64'(pending), 64'h8);
    tick(1);
    check("post_rst_take", 64'(int_take), 64'(1));
    check("post_rst_cause", 64'(qual_interrupcao), 64'(4));
    tick(1);
    os_return = 1;
    tick(1);
    os_return = 0;
    repeat (3000) begin
      if ($urandom_range(7) == 0) halt = ~halt;
      for (int i = 0; i < N - 2; i++) if ($urandom_range(7) == 0) irq_ext[i] = ~irq_ext[i];
      set_clock = $urandom_range(63) == 0;
      int_time = TW'($urandom_range(9));
      mask_write = $urandom_range(31) == 0;
      mask_data = N'($urandom);
      pc_next = AW'($urandom);
      get_interruption = $urandom_range(7) == 0;
      os_return = $urandom_range(5) == 0;
      tick(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
